// File: rtl/ppu_sprite_fetch.sv
// ---------------------------------------------------------------------------
// ppu_sprite_fetch
//
// Sprite pattern fetcher for the PPU. During dots 256-319 it walks the eight
// secondary-OAM entries, fetches both CHR pattern planes for each one from
// VRAM, applies horizontal/vertical flips and pushes one 27-bit load word per
// slot into the sprite shifter set. Slot 0 is loaded first.
//
// Ports:
//   clk          PPU dot clock
//   i_rst        synchronous, active-high reset
//   i_cycle      current dot (0-340)
//   i_oam_data   secondary-OAM byte addressed by i_cycle
//   i_obj_size   1 = 8x16 sprites
//   i_obj_patt   pattern table select for 8x8 sprites
//   i_rend_en    sprite rendering enable
//   i_vram_data  VRAM read data, valid one cycle after o_vram_rd
//   o_vram_addr  pattern fetch address
//   o_vram_rd    VRAM read strobe
//   o_load       shifter load mask, 4'b1111 for one cycle per slot
//   o_load_data  {pix1[7:0], pix2[7:0], x[7:0], pal[1:0], prio}
//   o_busy       high while the fetch window is active (dots 256-320)
//
// Configuration:
//   PPU_SPR_DUMMY_FETCH_EN  when defined, empty slots still issue both reads
//                           (tile 8'hFF, row 0) so mappers see A12 edges.
// ---------------------------------------------------------------------------
module ppu_sprite_fetch (
   input  logic        clk,
   input  logic        i_rst,
   input  logic [8:0]  i_cycle,
   input  logic [7:0]  i_oam_data,
   input  logic        i_obj_size,
   input  logic        i_obj_patt,
   input  logic        i_rend_en,
   input  logic [7:0]  i_vram_data,
   output logic [13:0] o_vram_addr,
   output logic        o_vram_rd,
   output logic [3:0]  o_load,
   output logic [26:0] o_load_data,
   output logic        o_busy
);

   typedef enum logic {
      ST_IDLE,
      ST_FETCH
   } state_t;

   state_t      state;

   logic [3:0]  row;
   logic        empty;
   logic [7:0]  tile;
   logic [7:0]  xpos;
   logic        vflip;
   logic        hflip;
   logic        prio;
   logic [1:0]  pal;
   logic [7:0]  plane_lo;

   logic [2:0]  slot;
   logic [2:0]  offset;
   logic        in_window;
   logic        start;
   logic        active;
   logic [3:0]  row_eff;
   logic [13:0] addr_lo;
   logic [13:0] addr_hi;
   logic [7:0]  pix1_next;
   logic [7:0]  pix2_next;
`ifdef PPU_SPR_DUMMY_FETCH_EN
   logic [13:0] dummy_lo;
   logic [13:0] dummy_hi;
`endif

   // Pattern address for one plane. 8x16 sprites take their table from
   // tile bit 0 and use row bit 3 to pick the top or bottom tile.
   function automatic logic [13:0] patt_addr(input logic [7:0] t,
                                             input logic [3:0] r,
                                             input logic       p,
                                             input logic       size16,
                                             input logic       patt);
      if (size16)
         patt_addr = {1'b0, t[0], t[7:1], r[3], p, r[2:0]};
      else
         patt_addr = {1'b0, patt, t, p, r[2:0]};
   endfunction

   function automatic logic [7:0] bit_rev(input logic [7:0] b);
      for (int i = 0; i < 8; i++)
         bit_rev[i] = b[7-i];
   endfunction

   // Decode the dot into slot/offset and decide whether this edge does work.
   // The window only starts at dot 256; once it drops out (disable or end
   // of slot 7) it stays idle until the next line.
   always_comb begin
      slot      = i_cycle[5:3];
      offset    = i_cycle[2:0];
      in_window = (i_cycle[8:6] == 3'b100);
      start     = (state == ST_IDLE) && (i_cycle == 9'd256);
      active    = i_rend_en && in_window && ((state == ST_FETCH) || start);

      // Vertical flip mirrors the row within the 8- or 16-line sprite.
      row_eff   = vflip ? (row ^ (i_obj_size ? 4'hF : 4'h7)) : row;
      addr_lo   = patt_addr(tile, row_eff, 1'b0, i_obj_size, i_obj_patt);
      addr_hi   = patt_addr(tile, row_eff, 1'b1, i_obj_size, i_obj_patt);

      // The shifter emits bit 0 first, so the unflipped sprite needs its
      // leftmost pixel (CHR bit 7) moved down to bit 0.
      pix1_next = hflip ? plane_lo    : bit_rev(plane_lo);
      pix2_next = hflip ? i_vram_data : bit_rev(i_vram_data);
`ifdef PPU_SPR_DUMMY_FETCH_EN
      dummy_lo  = patt_addr(8'hFF, 4'h0, 1'b0, i_obj_size, i_obj_patt);
      dummy_hi  = patt_addr(8'hFF, 4'h0, 1'b1, i_obj_size, i_obj_patt);
`endif
   end

   // Main sequencer. Each slot takes eight dots: OAM bytes at offsets 0-3,
   // low-plane read issued for offset 4 and captured at the end of offset 5,
   // high-plane read issued for offset 6 and captured at the end of offset 7,
   // where the load word is also built so it appears together with the pulse.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         state       <= ST_IDLE;
         row         <= '0;
         empty       <= 1'b0;
         tile        <= '0;
         xpos        <= '0;
         vflip       <= 1'b0;
         hflip       <= 1'b0;
         prio        <= 1'b0;
         pal         <= '0;
         plane_lo    <= '0;
         o_vram_addr <= '0;
         o_vram_rd   <= 1'b0;
         o_load      <= '0;
         o_load_data <= '0;
         o_busy      <= 1'b0;
      end else begin
         o_vram_rd <= 1'b0;
         o_load    <= '0;
         // Raised one dot early so busy covers dot 256 itself; the final
         // active edge (dot 319) keeps it high through dot 320.
         o_busy    <= ((i_cycle == 9'd255) && i_rend_en) || active;

         if (!active) begin
            state <= ST_IDLE;
         end else begin
            state <= ST_FETCH;
            case (offset)
               3'd0: begin
                  row   <= i_oam_data[3:0];
                  empty <= (i_oam_data[7:4] != 4'h0);
               end
               3'd1: tile <= i_oam_data;
               3'd2: begin
                  vflip <= i_oam_data[7];
                  hflip <= i_oam_data[6];
                  prio  <= i_oam_data[5];
                  pal   <= i_oam_data[1:0];
               end
               3'd3: begin
                  xpos <= i_oam_data;
`ifdef PPU_SPR_DUMMY_FETCH_EN
                  o_vram_rd   <= 1'b1;
                  o_vram_addr <= empty ? dummy_lo : addr_lo;
`else
                  if (!empty) begin
                     o_vram_rd   <= 1'b1;
                     o_vram_addr <= addr_lo;
                  end
`endif
               end
               3'd5: begin
                  plane_lo <= i_vram_data;
`ifdef PPU_SPR_DUMMY_FETCH_EN
                  o_vram_rd   <= 1'b1;
                  o_vram_addr <= empty ? dummy_hi : addr_hi;
`else
                  if (!empty) begin
                     o_vram_rd   <= 1'b1;
                     o_vram_addr <= addr_hi;
                  end
`endif
               end
               3'd7: begin
                  // Empty slots still load so every shifter is refreshed;
                  // X = 8'hFF keeps them off-screen.
                  o_load <= 4'b1111;
                  if (empty)
                     o_load_data <= {16'h0000, 8'hFF, pal, prio};
                  else
                     o_load_data <= {pix1_next, pix2_next, xpos, pal, prio};
                  if (slot == 3'd7)
                     state <= ST_IDLE;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
